// File: rtl/fb_pkg.sv
// Shared types and defaults for the SRAM framebuffer (reader and writer sides).
package fb_pkg;

  localparam int unsigned FB_H_RES = 640;
  localparam int unsigned FB_V_RES = 480;
  localparam int unsigned FB_WORDS = FB_H_RES * FB_V_RES;

  // One framebuffer pixel as stored in SRAM bits [11:0].
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  // Scan-out reader states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } reader_state_t;

  // The upper nibble of an SRAM word carries no pixel information.
  function automatic pixel_t word_to_pixel(input logic [15:0] word);
    return pixel_t'(word[11:0]);
  endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous clear and an
// occupancy count. The head entry is readable in the cycle after it is
// pushed; push and pop may happen in the same cycle. An empty FIFO drives 0.
module fb_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointer and count bookkeeping; clear wins over a simultaneous push/pop.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fb_sram_reader.sv
// Scan-out read engine: on each frame start, fetches H_RES*V_RES words in
// raster order from the SRAM controller read port and presents them as an
// RGB444 pixel stream.
//
// Handshakes: a transfer happens on a rising clock edge where valid/req and
// ready/gnt are both high. Once rd_req (or pix_valid) is raised, it and its
// payload stay unchanged until that transfer occurs; the only exception is a
// frame restart, which withdraws pix_valid and stops further requests.
module fb_sram_reader
  import fb_pkg::*;
#(
  parameter int unsigned    H_RES     = FB_H_RES,
  parameter int unsigned    V_RES     = FB_V_RES,
  parameter int unsigned    AW        = 20,
  parameter logic [AW-1:0]  BASE_ADDR = '0,
  parameter int unsigned    DEPTH     = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          frame_start,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_gnt,
  input  logic          rd_rvalid,
  input  logic [15:0]   rd_rdata,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [11:0]   pix_data,
  output logic          frame_done,
  output reader_state_t dbg_state
);

  localparam int unsigned WORDS = H_RES * V_RES;
  localparam int unsigned CW    = $clog2(WORDS + 1);
  localparam int unsigned OW    = $clog2(DEPTH + 1);

  reader_state_t r_state;
  reader_state_t w_next_state;

  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_issued;
  logic [CW-1:0] r_pix_cnt;
  logic [OW-1:0] r_outstanding;
  logic          r_frame_done;

  logic          w_rd_hs;
  logic          w_rsp;
  logic          w_push;
  logic          w_pix_hs;
  logic          w_last_pix;
  logic          w_issue_left;
  logic          w_credit_ok;
  logic [OW:0]   w_inflight;
  logic          w_fifo_clr;
  logic          w_frame_init;
  logic          w_frame_end;
  logic          w_fifo_empty;
  logic [OW-1:0] w_fifo_count;
  logic          w_unused_fifo_full;
  logic [3:0]    w_unused_rdata_hi;
  pixel_t        w_rsp_pix;
  logic [11:0]   w_fifo_dout;

  assign w_unused_rdata_hi = rd_rdata[15:12];
  assign w_rsp_pix         = word_to_pixel(rd_rdata);

  assign w_rd_hs      = rd_req && rd_gnt;
  // A response with nothing outstanding is a controller bug; it is ignored.
  assign w_rsp        = rd_rvalid && (r_outstanding != '0);
  assign w_push       = w_rsp && (r_state == ST_FETCH);
  assign w_pix_hs     = pix_valid && pix_ready;
  assign w_last_pix   = w_pix_hs && (r_pix_cnt == CW'(WORDS - 1));
  assign w_issue_left = (r_issued < CW'(WORDS));
  // Every outstanding request owns a FIFO slot, so the FIFO can never overflow.
  assign w_inflight   = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_credit_ok  = (w_inflight < (OW+1)'(DEPTH));

  assign rd_addr    = r_addr;
  assign frame_done = r_frame_done;
  assign pix_data   = w_fifo_dout;
  assign dbg_state  = r_state;

  fb_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(pixel_t))
  ) u_pix_fifo (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_clr   (w_fifo_clr),
    .i_push  (w_push),
    .i_din   (w_rsp_pix),
    .i_pop   (w_pix_hs),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_full  (w_unused_fifo_full),
    .o_count (w_fifo_count)
  );

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state and per-state strobes. A restart during FETCH still lets the
  // request on the bus that cycle complete; it is then drained in FLUSH.
  always_comb begin
    w_next_state = r_state;
    rd_req       = 1'b0;
    pix_valid    = 1'b0;
    w_fifo_clr   = 1'b0;
    w_frame_init = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_start) begin
          w_next_state = ST_FETCH;
          w_frame_init = 1'b1;
        end
      end
      ST_FETCH: begin
        rd_req    = w_issue_left && w_credit_ok;
        pix_valid = !w_fifo_empty;
        if (frame_start) begin
          w_next_state = ST_FLUSH;
          w_fifo_clr   = 1'b1;
        end else if (w_last_pix) begin
          w_next_state = ST_IDLE;
          w_frame_end  = 1'b1;
        end
      end
      ST_FLUSH: begin
        w_fifo_clr = 1'b1;
        if (r_outstanding == '0) begin
          w_next_state = ST_FETCH;
          w_frame_init = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Address, issue/pixel/outstanding counters and the frame_done pulse.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_addr        <= BASE_ADDR;
      r_issued      <= '0;
      r_pix_cnt     <= '0;
      r_outstanding <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_outstanding <= r_outstanding + OW'(w_rd_hs) - OW'(w_rsp);
      r_frame_done  <= w_frame_end;
      if (w_frame_init) begin
        r_addr    <= BASE_ADDR;
        r_issued  <= '0;
        r_pix_cnt <= '0;
      end else begin
        if (w_rd_hs) begin
          r_addr   <= r_addr + AW'(1);
          r_issued <= r_issued + CW'(1);
        end
        if (w_pix_hs) begin
          r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + CW'(1);
        end
      end
    end
  end

  // Responses must never outnumber requests.
  a_no_spurious_rvalid : assert property (@(posedge sys_clk) disable iff (sys_rst)
    !(rd_rvalid && (r_outstanding == '0)));

endmodule

// File: tb/tb_fb_sram_reader.sv
// Directed bench for fb_sram_reader on a 4x4 frame at word base 0x10000.
module tb_fb_sram_reader;
  import fb_pkg::*;

  localparam int              WORDS = 16;
  localparam int              AW    = 20;
  localparam logic [AW-1:0]   BASE  = 20'h10000;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          rd_gnt = 1'b0;
  logic          rd_rvalid = 1'b0;
  logic [15:0]   rd_rdata = 16'h0;
  logic          pix_ready = 1'b0;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          pix_valid;
  logic [11:0]   pix_data;
  logic          frame_done;
  reader_state_t dbg_state;

  fb_sram_reader #(
    .H_RES(4), .V_RES(4), .AW(AW), .BASE_ADDR(BASE), .DEPTH(8)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .frame_start(frame_start),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 sys_clk = ~sys_clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SRAM contents: upper nibble is junk the reader must drop.
  logic [15:0] sram [WORDS];

  // Bus model / scoreboard state
  int          cyc = 0;
  bit          gnt_on = 0, gnt_rand = 0, ready_on = 0, ready_rand = 0;
  int          lat = 2;
  int          pend_idx[$];
  int          pend_due[$];
  int          req_idx = 0, grants = 0, accepted = 0, done_cnt = 0;
  int          first_req_cyc = -1, last_acc = -1, done_cyc = -1, max_occ = 0;
  bit          restart_pending = 0;
  logic        prev_req = 1'b0, prev_gnt = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [11:0] exp_q[$];

  // SRAM controller model and pixel sink; all inputs change on the falling
  // edge, cyc is the index of the upcoming rising edge.
  always @(negedge sys_clk) begin
    cyc++;
    if (sys_rst) begin
      pend_idx.delete();
      pend_due.delete();
      rd_rvalid = 1'b0;
      rd_gnt    = 1'b0;
      prev_req  = 1'b0;
      prev_gnt  = 1'b0;
    end else begin
      if (prev_req && !prev_gnt) begin
        check_eq("req_hold", 32'(rd_req), 32'd1);
        check_eq("addr_hold", 32'(rd_addr), 32'(prev_addr));
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        rd_rvalid = 1'b1;
        rd_rdata  = sram[pend_idx[0]];
        void'(pend_due.pop_front());
        void'(pend_idx.pop_front());
      end else begin
        rd_rvalid = 1'b0;
        rd_rdata  = 16'h0;
      end
      rd_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_on;
      if (rd_req && rd_gnt) begin
        if (restart_pending) begin
          check_eq("drain_before_restart", 32'(pend_due.size()), 32'd0);
          req_idx = 0;
          restart_pending = 0;
        end
        check_eq("rd_addr", 32'(rd_addr), 32'(BASE + AW'(req_idx)));
        pend_idx.push_back(req_idx % WORDS);
        pend_due.push_back(cyc + lat);
        req_idx++;
        grants++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      prev_req  = rd_req;
      prev_gnt  = rd_gnt;
      prev_addr = rd_addr;
      pix_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_on;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) check_eq("pix_extra", 32'(exp_q.size()), 32'd1);
        else check_eq("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
        accepted++;
        last_acc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("done_after_last", 32'(last_acc), 32'(cyc - 1));
      end
      if (grants - accepted > max_occ) max_occ = grants - accepted;
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic prime_frame();
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) exp_q.push_back(sram[i][11:0]);
    req_idx = 0; grants = 0; accepted = 0;
    first_req_cyc = -1; done_cyc = -1; max_occ = 0;
  endtask

  task automatic pulse_start(output int s);
    frame_start = 1'b1;
    s = cyc;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, input int bound);
    int n = 0;
    while (done_cnt == start_cnt && n < bound) begin
      tick(1);
      n++;
    end
    check_eq("frame_done_seen", 32'(done_cnt - start_cnt), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_req"},     32'(rd_req),     32'd0);
    check_eq({tag, "_rd_addr"},    32'(rd_addr),    32'(BASE));
    check_eq({tag, "_pix_valid"},  32'(pix_valid),  32'd0);
    check_eq({tag, "_pix_data"},   32'(pix_data),   32'd0);
    check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check_eq({tag, "_state"},      32'(dbg_state),  32'(ST_IDLE));
  endtask

  int s;
  int d0;
  int n;

  initial begin
    sram = '{16'hFABC, 16'h1123, 16'h2456, 16'h3789, 16'h4ABC, 16'h5DEF,
             16'h6F00, 16'h70FF, 16'h8555, 16'h9AAA, 16'hA001, 16'hB800,
             16'hC0F0, 16'hDF0F, 16'hE321, 16'hF654};

    // Reset state
    sys_rst = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    sys_rst = 1'b0;
    tick(2);

    // Full-rate frame: grant always, 2-cycle latency, sink always ready
    gnt_on = 1; ready_on = 1; lat = 2;
    prime_frame();
    d0 = done_cnt;
    pulse_start(s);
    wait_done(d0, 200);
    check_eq("t1_first_req", 32'(first_req_cyc), 32'(s + 1));
    check_eq("t1_done_cycle", 32'(done_cyc), 32'(s + WORDS + 4));
    check_eq("t1_accepted", 32'(accepted), 32'(WORDS));
    check_eq("t1_grants", 32'(grants), 32'(WORDS));
    check_eq("t1_exp_left", 32'(exp_q.size()), 32'd0);
    check_eq("t1_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("t1_req_idle", 32'(rd_req), 32'd0);
    tick(2);
    check_eq("t1_single_done", 32'(done_cnt - d0), 32'd1);

    // Backpressure: sink stalled, requests must stop at FIFO depth
    ready_on = 0;
    prime_frame();
    d0 = done_cnt;
    pulse_start(s);
    tick(30);
    check_eq("t2_grants_stalled", 32'(grants), 32'd8);
    check_eq("t2_req_low", 32'(rd_req), 32'd0);
    check_eq("t2_accepted_stalled", 32'(accepted), 32'd0);
    check_eq("t2_pix_valid", 32'(pix_valid), 32'd1);
    check_eq("t2_head_pixel", 32'(pix_data), 32'h0ABC);
    ready_on = 1;
    wait_done(d0, 200);
    check_eq("t2_accepted", 32'(accepted), 32'(WORDS));
    check_eq("t2_grants", 32'(grants), 32'(WORDS));
    check_eq("t2_exp_left", 32'(exp_q.size()), 32'd0);
    check_eq("t2_max_occ", 32'(max_occ), 32'd8);

    // Random grant and random sink ready
    gnt_rand = 1; ready_rand = 1;
    prime_frame();
    d0 = done_cnt;
    pulse_start(s);
    wait_done(d0, 2000);
    check_eq("t3_accepted", 32'(accepted), 32'(WORDS));
    check_eq("t3_grants", 32'(grants), 32'(WORDS));
    check_eq("t3_exp_left", 32'(exp_q.size()), 32'd0);
    gnt_rand = 0; ready_rand = 0;
    tick(2);

    // Restart at pixel 3 with three responses in flight
    gnt_on = 1; ready_on = 1; lat = 3;
    prime_frame();
    d0 = done_cnt;
    pulse_start(s);
    n = 0;
    while (accepted < 3 && n < 50) begin
      tick(1);
      n++;
    end
    check_eq("t4_accepted_before", 32'(accepted), 32'd3);
    check_eq("t4_inflight", 32'(pend_due.size()), 32'd3);
    frame_start = 1'b1;
    restart_pending = 1;
    prime_frame();
    tick(1);
    frame_start = 1'b0;
    tick(1);
    check_eq("t4_state_flush", 32'(dbg_state), 32'(ST_FLUSH));
    check_eq("t4_req_flush", 32'(rd_req), 32'd0);
    check_eq("t4_pix_valid_flush", 32'(pix_valid), 32'd0);
    wait_done(d0, 200);
    check_eq("t4_accepted", 32'(accepted), 32'(WORDS));
    check_eq("t4_grants", 32'(grants), 32'(WORDS));
    check_eq("t4_exp_left", 32'(exp_q.size()), 32'd0);
    tick(2);
    check_eq("t4_single_done", 32'(done_cnt - d0), 32'd1);

    // Reset mid-fetch, then a clean frame
    lat = 2;
    prime_frame();
    pulse_start(s);
    tick(5);
    sys_rst = 1'b1;
    tick(1);
    check_reset_outputs("midrst");
    sys_rst = 1'b0;
    tick(2);
    check_eq("t5_idle_after_rst", 32'(rd_req), 32'd0);
    prime_frame();
    d0 = done_cnt;
    pulse_start(s);
    wait_done(d0, 200);
    check_eq("t5_first_req", 32'(first_req_cyc), 32'(s + 1));
    check_eq("t5_done_cycle", 32'(done_cyc), 32'(s + WORDS + 4));
    check_eq("t5_accepted", 32'(accepted), 32'(WORDS));
    check_eq("t5_exp_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
